// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: host pushes with wr_en/wr_data, the
// transmitter sees the head byte first-word-fall-through and pops it with tx_rd.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic          tx_ready,
  input  logic          tx_rd,
  output logic [7:0]    tx_data
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Handshake: tx_ready is "valid" (head byte on tx_data); tx_rd is a one-cycle
  // pop that takes effect only when tx_ready=1. tx_data holds until that edge.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          empty;
  logic          at_full;
  logic          pop;
  logic          push;

  assign empty    = (cnt == '0);
  assign at_full  = (cnt == DEPTH_CNT);
  assign pop      = tx_rd && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = wr_en && (!at_full || pop);

  assign tx_ready = !empty;
  assign full     = at_full;
  assign count    = cnt;
  assign tx_data  = mem[rp];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (wr_en && at_full && !tx_rd) overflow  <= 1'b1;
      if (tx_rd && empty)             underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wp] <= wr_data;
  end

endmodule
